// File: rtl/ddr_line_fetch_if.sv
// Memory-side bus between the line fetcher (master) and the DDR controller's
// 960b capture channels (slave).
// Handshake: mem_rd is a single-cycle request pulse carrying mem_addr, mem_rd_ch and
// mem_burst. At most one read is in flight. mem_dready is a single-cycle pulse once
// the burst sits in that channel. mem960_dout shows the channel picked by mem_dout_ch.
interface ddr_line_fetch_if;
  logic [26:0]  mem_addr;
  logic         mem_rd;
  logic         mem_rd_ch;
  logic [7:0]   mem_burst;
  logic         mem_dout_ch;
  logic         mem_busy;
  logic         mem_dready;
  logic [959:0] mem960_dout;

  modport master (
    output mem_addr, mem_rd, mem_rd_ch, mem_burst, mem_dout_ch,
    input  mem_busy, mem_dready, mem960_dout
  );

  modport slave (
    input  mem_addr, mem_rd, mem_rd_ch, mem_burst, mem_dout_ch,
    output mem_busy, mem_dready, mem960_dout
  );
endinterface

// File: rtl/ddr_line_fetch.sv
// Fetches one line of packed 24bpp pixels as ping-pong chunk reads and serialises them
// to a FWFT pixel port. Define LINE_FETCH_STATS_EN to add the underrun_cnt output.
module ddr_line_fetch #(
  parameter int WORDS = 15
) (
  input  logic        DDRAM_CLK,
  input  logic        reset,
  input  logic        line_start,
  input  logic [26:0] line_base,
  input  logic [11:0] line_pixels,
  input  logic        pix_rd,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  output logic        line_done,
  output logic        underrun,
  output logic [1:0]  dbg_state_o,
`ifdef LINE_FETCH_STATS_EN
  output logic [15:0] underrun_cnt,
`endif
  ddr_line_fetch_if.master mem
);
  localparam int              CPX       = WORDS * 8 / 3;
  localparam int              KW        = $clog2(CPX);
  localparam logic [26:0]     ADDR_STEP = 27'(WORDS * 4);
  localparam logic [11:0]     CPX_W     = 12'(CPX);
  localparam logic [KW-1:0]   K_LAST    = KW'(CPX - 1);

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_CHECK = 2'd1;
  localparam logic [1:0] R_ISSUE = 2'd2;
  localparam logic [1:0] R_WAIT  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [26:0]   addr_q, addr_d;
  logic [11:0]   req_left_q, req_left_d;   // pixels not yet covered by a completed chunk
  logic [11:0]   pix_left_q, pix_left_d;
  logic [KW-1:0] k_q, k_d;
  logic [1:0]    full_q, full_d;
  logic          wch_q, wch_d;
  logic          rch_q, rch_d;
  logic          active_q, active_d;
  logic          drain_q, drain_d;
  logic          done_q, done_d;
  logic          underrun_q, underrun_d;

  logic          pop, last_pix, chunk_rel, miss, outstanding;
  logic [9:0]    pix_sel;
  logic          unused_base;

  assign unused_base = ^line_base[1:0];

  assign pix_valid = full_q[rch_q] && active_q && (pix_left_q != 12'd0);
  assign pix_sel   = 10'(k_q) * 10'd24;
  assign pix_data  = pix_valid ? mem.mem960_dout[pix_sel +: 24] : 24'd0;

  assign pop         = pix_rd && pix_valid;
  assign miss        = pix_rd && !pix_valid && active_q;
  assign last_pix    = (pix_left_q == 12'd1);
  assign chunk_rel   = pop && ((k_q == K_LAST) || last_pix);
  assign outstanding = (state_q == R_ISSUE) || ((state_q == R_WAIT) && !mem.mem_dready);

  assign line_done   = done_q;
  assign underrun    = underrun_q;
  assign dbg_state_o = state_q;

  assign mem.mem_rd      = (state_q == R_ISSUE);
  assign mem.mem_rd_ch   = wch_q;
  assign mem.mem_addr    = addr_q;
  assign mem.mem_burst   = 8'(WORDS);
  assign mem.mem_dout_ch = rch_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    pix_left_d = pix_left_q;
    k_d        = k_q;
    full_d     = full_q;
    wch_d      = wch_q;
    rch_d      = rch_q;
    active_d   = active_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    underrun_d = underrun_q;

    if (line_start) begin
      // A read already handed to the controller must complete before the next one.
      state_d    = outstanding ? R_WAIT : ((line_pixels != 12'd0) ? R_CHECK : R_IDLE);
      drain_d    = outstanding;
      addr_d     = {line_base[26:2], 2'b00};
      req_left_d = line_pixels;
      pix_left_d = line_pixels;
      k_d        = '0;
      full_d     = 2'b00;
      wch_d      = 1'b0;
      rch_d      = 1'b0;
      active_d   = (line_pixels != 12'd0);
      underrun_d = 1'b0;
    end else begin
      if (miss) underrun_d = 1'b1;

      case (state_q)
        R_IDLE: ;
        R_CHECK: begin
          if ((req_left_q != 12'd0) && !full_q[wch_q] && !mem.mem_busy) state_d = R_ISSUE;
        end
        R_ISSUE: state_d = R_WAIT;
        R_WAIT: begin
          if (mem.mem_dready) begin
            if (drain_q) begin
              drain_d = 1'b0;
              state_d = active_q ? R_CHECK : R_IDLE;
            end else begin
              full_d[wch_q] = 1'b1;
              wch_d         = ~wch_q;
              addr_d        = addr_q + ADDR_STEP;
              req_left_d    = (req_left_q > CPX_W) ? (req_left_q - CPX_W) : 12'd0;
              state_d       = R_CHECK;
            end
          end
        end
        default: state_d = R_IDLE;
      endcase

      // Capture fills wch while release empties rch; they never name the same channel here.
      if (pop) begin
        pix_left_d = pix_left_q - 12'd1;
        k_d        = k_q + KW'(1);
        if (chunk_rel) begin
          full_d[rch_q] = 1'b0;
          rch_d         = ~rch_q;
          k_d           = '0;
        end
        if (last_pix) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = R_IDLE;
        end
      end
    end
  end

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      state_q    <= R_IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      pix_left_q <= '0;
      k_q        <= '0;
      full_q     <= 2'b00;
      wch_q      <= 1'b0;
      rch_q      <= 1'b0;
      active_q   <= 1'b0;
      drain_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      pix_left_q <= pix_left_d;
      k_q        <= k_d;
      full_q     <= full_d;
      wch_q      <= wch_d;
      rch_q      <= rch_d;
      active_q   <= active_d;
      drain_q    <= drain_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] underrun_cnt_q;

  assign underrun_cnt = underrun_cnt_q;

  always_ff @(posedge DDRAM_CLK) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else if (miss && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_line_fetch.sv
// Bench for ddr_line_fetch: a behavioural DDR controller model feeds random chunk data,
// and each line's expected pixel stream and read addresses come from plain arithmetic.
module tb_ddr_line_fetch;
  localparam int WORDS = 15;
  localparam int CPX   = WORDS * 8 / 3;

  logic        DDRAM_CLK;
  logic        reset;
  logic        line_start;
  logic [26:0] line_base;
  logic [11:0] line_pixels;
  logic        pix_rd;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        line_done;
  logic        underrun;
  logic [1:0]  dbg_state;
`ifdef LINE_FETCH_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  ddr_line_fetch_if mif();

  logic [959:0] ch0_data, ch1_data;
  logic         pend;
  logic         force_busy;

  assign mif.mem960_dout = mif.mem_dout_ch ? ch1_data : ch0_data;
  assign mif.mem_busy    = pend | force_busy;

  logic [23:0] exp_q[$];
  logic [26:0] exp_addr_q[$];
  logic        exp_ch_q[$];

  int checks    = 0;
  int errors    = 0;
  int n_reads   = 0;
  int cur_gen   = 0;
  int deliv_idx = 0;
  int line_n    = 0;

  ddr_line_fetch #(.WORDS(WORDS)) dut (
    .DDRAM_CLK   (DDRAM_CLK),
    .reset       (reset),
    .line_start  (line_start),
    .line_base   (line_base),
    .line_pixels (line_pixels),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .line_done   (line_done),
    .underrun    (underrun),
    .dbg_state_o (dbg_state),
`ifdef LINE_FETCH_STATS_EN
    .underrun_cnt(underrun_cnt),
`endif
    .mem         (mif)
  );

  // ---------------- clock / reset ----------------
  initial DDRAM_CLK = 1'b0;
  always #5 DDRAM_CLK = ~DDRAM_CLK;

  task automatic tick();
    @(posedge DDRAM_CLK);
    #2;
  endtask

  // ---------------- controller model + request scoreboard ----------------
  initial begin : ctrl_model
    int          lat;
    int          pend_gen;
    int          rem;
    int          cnt;
    logic        pend_ch;
    logic [959:0] data;
    logic [26:0] ea;
    logic        ec;
    pend = 1'b0;
    mif.mem_dready = 1'b0;
    ch0_data = '0;
    ch1_data = '0;
    lat = 0;
    pend_gen = 0;
    pend_ch = 1'b0;
    forever begin
      @(posedge DDRAM_CLK);
      #1;
      mif.mem_dready = 1'b0;
      if (mif.mem_rd === 1'b1) begin
        n_reads++;
        checks++;
        if (pend) begin
          errors++;
          $display("FAIL rd_overlap: got mem_rd=1 with a read outstanding, expected 0");
        end
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL extra_rd: got mem_rd at addr %h, expected no read", mif.mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          ec = exp_ch_q.pop_front();
          if (mif.mem_addr !== ea || mif.mem_rd_ch !== ec || mif.mem_burst !== 8'(WORDS)) begin
            errors++;
            $display("FAIL rd_req: got addr %h ch %0d burst %0d, expected addr %h ch %0d burst %0d",
                     mif.mem_addr, mif.mem_rd_ch, mif.mem_burst, ea, ec, WORDS);
          end
        end
        pend = 1'b1;
        pend_ch = mif.mem_rd_ch;
        pend_gen = cur_gen;
        lat = $urandom_range(3, 8);
      end else if (pend) begin
        lat--;
        if (lat == 0) begin
          for (int w = 0; w < 30; w++) data[w*32 +: 32] = $urandom();
          if (pend_ch) ch1_data = data;
          else ch0_data = data;
          pend = 1'b0;
          mif.mem_dready = 1'b1;
          if (pend_gen == cur_gen) begin
            rem = line_n - deliv_idx * CPX;
            cnt = (rem < CPX) ? rem : CPX;
            for (int p = 0; p < cnt; p++) exp_q.push_back(data[p*24 +: 24]);
            deliv_idx++;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_line(input logic [26:0] base, input int n);
    logic [26:0] b;
    int nch;
    cur_gen++;
    deliv_idx = 0;
    line_n = n;
    exp_q.delete();
    exp_addr_q.delete();
    exp_ch_q.delete();
    b = {base[26:2], 2'b00};
    nch = (n + CPX - 1) / CPX;
    for (int c = 0; c < nch; c++) begin
      exp_addr_q.push_back(b + 27'(c * WORDS * 4));
      exp_ch_q.push_back(1'(c % 2));
    end
    line_base = base;
    line_pixels = 12'(n);
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  // Pops n pixels with the given read probability; checks data, then the line_done pulse.
  task automatic consume(input int n, input int pct, input int budget);
    int got = 0;
    int cyc = 0;
    logic [23:0] e;
    while (got < n && cyc < budget) begin
      pix_rd = ($urandom_range(1, 100) <= pct);
      if (pix_rd && pix_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pix_extra: got pixel %h, expected none", pix_data);
        end else begin
          e = exp_q.pop_front();
          if (pix_data !== e) begin
            errors++;
            $display("FAIL pix_data[%0d]: got %h, expected %h", got, pix_data, e);
          end
        end
        got++;
      end
      checks++;
      if (line_done !== 1'b0) begin
        errors++;
        $display("FAIL early_done: got line_done=%b at pixel %0d, expected 0", line_done, got);
      end
      tick();
      cyc++;
    end
    pix_rd = 1'b0;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL pix_timeout: got %0d pixels, expected %0d", got, n);
    end
    checks++;
    if (line_done !== 1'b1 || pix_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL line_end: got done=%b valid=%b left=%0d, expected done=1 valid=0 left=0",
               line_done, pix_valid, exp_q.size());
    end
    tick();
    checks++;
    if (line_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got line_done=%b, expected 0", line_done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({pix_data, pix_valid, line_done, underrun, mif.mem_addr, mif.mem_rd,
         mif.mem_rd_ch, mif.mem_dout_ch} !== '0 || mif.mem_burst !== 8'(WORDS)) begin
      errors++;
      $display("FAIL reset_out: got data %h valid %b done %b addr %h rd %b burst %0d, expected zeros, burst %0d",
               pix_data, pix_valid, line_done, mif.mem_addr, mif.mem_rd, mif.mem_burst, WORDS);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_chunk();
    int r0 = n_reads;
    start_line(27'h80, 40);
    checks++;
    if (mif.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency1: got mem_rd=%b one cycle after line_start, expected 0", mif.mem_rd);
    end
    tick();
    checks++;
    if (mif.mem_rd !== 1'b1 || mif.mem_addr !== 27'h80 || mif.mem_rd_ch !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency2: got rd=%b addr %h ch %b, expected rd=1 addr 080 ch 0",
               mif.mem_rd, mif.mem_addr, mif.mem_rd_ch);
    end
    consume(40, 100, 500);
    repeat (20) tick();
    checks++;
    if (n_reads - r0 != 1) begin
      errors++;
      $display("FAIL single_reads: got %0d reads, expected 1", n_reads - r0);
    end
  endtask

  task automatic test_three_chunks();
    int r0 = n_reads;
    start_line(27'h80, 100);
    repeat (60) tick();
    checks++;
    if (n_reads - r0 != 2) begin
      errors++;
      $display("FAIL ping_pong_stall: got %0d reads before draining, expected 2", n_reads - r0);
    end
    consume(100, 100, 2000);
    checks++;
    if (n_reads - r0 != 3) begin
      errors++;
      $display("FAIL three_reads: got %0d reads, expected 3", n_reads - r0);
    end
  endtask

  task automatic test_underrun();
    start_line(27'h200, 40);
    pix_rd = 1'b1;
    tick();
    checks++;
    if (underrun !== 1'b1 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL underrun_set: got underrun=%b valid=%b, expected 1 0", underrun, pix_valid);
    end
    consume(40, 100, 500);
    checks++;
    if (underrun !== 1'b1) begin
      errors++;
      $display("FAIL underrun_sticky: got %b, expected 1", underrun);
    end
    start_line(27'h300, 30);
    checks++;
    if (underrun !== 1'b0) begin
      errors++;
      $display("FAIL underrun_clear: got %b, expected 0", underrun);
    end
    consume(30, 100, 500);
  endtask

  task automatic test_restart();
    int r0;
    int cyc = 0;
    start_line(27'h400, 120);
    r0 = n_reads;
    while (n_reads == r0 && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (n_reads == r0) begin
      errors++;
      $display("FAIL restart_first_rd: got no read, expected 1");
    end
    start_line(27'h2000, 60);
    cyc = 0;
    while (deliv_idx == 0 && cyc < 100) begin
      checks++;
      if (pix_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_valid: got pix_valid=%b before new data, expected 0", pix_valid);
      end
      tick();
      cyc++;
    end
    consume(60, 80, 3000);
  endtask

  task automatic test_busy();
    force_busy = 1'b1;
    start_line(27'h800, 50);
    repeat (10) begin
      tick();
      checks++;
      if (mif.mem_rd !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold: got mem_rd=%b while busy, expected 0", mif.mem_rd);
      end
    end
    force_busy = 1'b0;
    tick();
    checks++;
    if (mif.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL busy_release: got mem_rd=%b after busy fell, expected 1", mif.mem_rd);
    end
    consume(50, 100, 1000);
  endtask

  task automatic test_random_lines();
    int n_tab[4] = '{1, 39, 41, 80};
    int n;
    for (int i = 0; i < 7; i++) begin
      n = (i < 4) ? n_tab[i] : $urandom_range(1, 300);
      start_line(27'($urandom()), n);
      consume(n, $urandom_range(30, 100), n * 40 + 300);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    logic [23:0] e;
    start_line(27'h1000, 200);
    pix_rd = 1'b1;
    repeat (60) begin
      if (pix_valid) begin
        checks++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hx;
        if (pix_data !== e) begin
          errors++;
          $display("FAIL mid_pix: got %h, expected %h", pix_data, e);
        end
      end
      tick();
    end
    pix_rd = 1'b0;
    reset = 1'b1;
    cur_gen++;
    exp_q.delete();
    exp_addr_q.delete();
    exp_ch_q.delete();
    tick();
    checks++;
    if ({pix_data, pix_valid, line_done, underrun, mif.mem_addr, mif.mem_rd,
         mif.mem_rd_ch, mif.mem_dout_ch} !== '0 || mif.mem_burst !== 8'(WORDS)) begin
      errors++;
      $display("FAIL mid_reset_out: got data %h valid %b addr %h rd %b ch %b dch %b, expected zeros",
               pix_data, pix_valid, mif.mem_addr, mif.mem_rd, mif.mem_rd_ch, mif.mem_dout_ch);
    end
    reset = 1'b0;
    r0 = n_reads;
    repeat (30) tick();
    checks++;
    if (n_reads != r0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d reads valid=%b, expected 0 reads valid=0",
               n_reads - r0, pix_valid);
    end
  endtask

`ifdef LINE_FETCH_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset: got %0d, expected 0", underrun_cnt);
    end
    force_busy = 1'b1;
    start_line(27'h40, 40);
    pix_rd = 1'b1;
    repeat (5) tick();
    pix_rd = 1'b0;
    tick();
    checks++;
    if (underrun_cnt !== 16'd5) begin
      errors++;
      $display("FAIL stats_count: got %0d, expected 5", underrun_cnt);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_busy = 1'b0;
    cur_gen++;
    exp_addr_q.delete();
    exp_ch_q.delete();
    tick();
  endtask
`endif

  initial begin
    reset = 1'b1;
    line_start = 1'b0;
    line_base = '0;
    line_pixels = '0;
    pix_rd = 1'b0;
    force_busy = 1'b0;
    test_reset();
    test_single_chunk();
    test_three_chunks();
    test_underrun();
    test_restart();
    test_busy();
    test_random_lines();
    test_reset_mid();
`ifdef LINE_FETCH_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
